// File: rtl/int_ctrl.sv
// Vectored interrupt controller: per-source edge/level capture, mask, global enable,
// fixed lowest-index-first priority, and a non-nesting IDLE/REQ/SERVICE handshake with the CPU.
module int_ctrl #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0004,
  parameter int          VEC_SHIFT = 3,
  localparam int         ID_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             int_req,
  input  logic             int_ack,
  output logic [ID_W-1:0]  int_id,
  output logic [31:0]      int_vec,
  input  logic             eret,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] A_MASK = 2'd0, A_MODE = 2'd1, A_PEND = 2'd2, A_STAT = 2'd3;

  state_e            state_q;
  logic [N_SRC-1:0]  mask_q, mode_q, pend_q, hist_q;
  logic [N_SRC-1:0]  pend_d, rise, w1c, ack_clr, eligible;
  logic              gie_q, int_req_q, busy_q;
  logic [ID_W-1:0]   id_q, win_id;

  assign rise     = irq_src & ~hist_q;
  assign w1c      = (cfg_we && cfg_addr == A_PEND) ? cfg_wdata[N_SRC-1:0] : '0;
  assign ack_clr  = (state_q == S_REQ && int_ack) ? (N_SRC'(1) << id_q) : '0;
  // Edge bits: a fresh rising edge beats both a W1C write and the ack clear.
  assign pend_d   = (mode_q & (rise | (pend_q & ~w1c & ~ack_clr))) | (~mode_q & irq_src);
  assign eligible = pend_q & mask_q & {N_SRC{gie_q}};

  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      hist_q <= '0;
      gie_q  <= 1'b0;
    end else begin
      hist_q <= irq_src;
      pend_q <= pend_d;
      if (cfg_we) begin
        case (cfg_addr)
          A_MASK:  mask_q <= cfg_wdata[N_SRC-1:0];
          A_MODE:  mode_q <= cfg_wdata[N_SRC-1:0];
          A_STAT:  gie_q  <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // CPU handshake: int_req holds with a stable id until int_ack (one-cycle pulse)
  // is seen in REQ; eret (one-cycle pulse) ends SERVICE. Pulses in other states are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      int_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|eligible) begin
            id_q      <= win_id;
            int_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            int_req_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_SERVICE;
          end else if (!eligible[id_q]) begin
            int_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (eret) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          int_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign int_req     = int_req_q;
  assign busy        = busy_q;
  assign int_id      = id_q;
  assign int_vec     = VEC_BASE + (32'(id_q) << VEC_SHIFT);
  assign dbg_state_o = state_q;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      A_MASK:  cfg_rdata = 32'(mask_q);
      A_MODE:  cfg_rdata = 32'(mode_q);
      A_PEND:  cfg_rdata = 32'(pend_q);
      default: cfg_rdata = {16'h0, 8'(id_q), 6'h0, busy_q, gie_q};
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset state, latency, priority, level drop-out,
// no-nesting, W1C vs. new edge, config timing and asynchronous reset.
module tb_int_ctrl;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] irq_src;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic             int_req;
  logic             int_ack;
  logic [ID_W-1:0]  int_id;
  logic [31:0]      int_vec;
  logic             eret;
  logic             busy;
  logic [1:0]       dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  int_ctrl #(.N_SRC(N_SRC), .VEC_BASE(32'h0000_0004), .VEC_SHIFT(3)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .int_req(int_req), .int_ack(int_ack), .int_id(int_id), .int_vec(int_vec),
    .eret(eret), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    cfg_addr = addr;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  task automatic pulse_src(input logic [N_SRC-1:0] bits);
    irq_src = bits;
    tick();
    irq_src = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    int_ack = 1'b0; eret = 1'b0;
    tick(); tick(); tick();

    // reset state
    check("rst_int_req", 32'(int_req), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_int_id",  32'(int_id),  32'h0);
    check("rst_int_vec", int_vec,      32'h4);
    check("rst_state",   32'(dbg_state), 32'h0);
    read_chk("rst_mask",   2'd0, 32'h0);
    read_chk("rst_mode",   2'd1, 32'h0);
    read_chk("rst_status", 2'd3, 32'h0);
    reset = 1'b1;
    tick();

    cfg_write(2'd0, 32'hFF);
    cfg_write(2'd1, 32'hFF);
    cfg_write(2'd3, 32'h1);
    read_chk("cfg_status_gie", 2'd3, 32'h1);

    // single edge on src 2: pending at edge k, request after k+1
    pulse_src(8'h04);
    check("lat_req_k", 32'(int_req), 32'h0);
    read_chk("lat_pend_k", 2'd2, 32'h4);
    tick();
    check("lat_req_k1", 32'(int_req), 32'h1);
    check("lat_id",     32'(int_id),  32'h2);
    check("lat_vec",    int_vec,      32'h14);
    check("lat_state",  32'(dbg_state), 32'h1);
    ack();
    check("ack_busy",    32'(busy),    32'h1);
    check("ack_int_req", 32'(int_req), 32'h0);
    read_chk("ack_pend_clr", 2'd2, 32'h0);
    do_eret();
    check("eret_busy",  32'(busy),      32'h0);
    check("eret_state", 32'(dbg_state), 32'h0);

    // simultaneous 5 and 1: lowest index first, then back-to-back
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd5);
    pulse_src(8'h22);
    tick();
    check("pri_req",   32'(int_req), 32'h1);
    check("pri_id1",   32'(int_id),  exp_q.pop_front());
    check("pri_vec1",  int_vec,      32'h0C);
    ack();
    read_chk("pri_pend_left", 2'd2, 32'h20);
    do_eret();
    check("b2b_idle_req",   32'(int_req),   32'h0);
    check("b2b_idle_state", 32'(dbg_state), 32'h0);
    tick();
    check("b2b_req",  32'(int_req), 32'h1);
    check("b2b_id5",  32'(int_id),  exp_q.pop_front());
    check("b2b_vec5", int_vec,      32'h2C);
    ack();
    do_eret();

    // level source 3 drops before ack
    cfg_write(2'd1, 32'hF7);
    irq_src = 8'h08;
    tick();
    tick();
    check("lvl_req",  32'(int_req), 32'h1);
    check("lvl_id",   32'(int_id),  32'h3);
    irq_src = 8'h00;
    tick();
    check("lvl_req_hold", 32'(int_req), 32'h1);
    read_chk("lvl_pend_drop", 2'd2, 32'h0);
    tick();
    check("lvl_drop_req",   32'(int_req),   32'h0);
    check("lvl_drop_state", 32'(dbg_state), 32'h0);
    check("lvl_drop_busy",  32'(busy),      32'h0);
    cfg_write(2'd1, 32'hFF);

    // mask write takes effect one edge later
    cfg_write(2'd0, 32'h00);
    pulse_src(8'h80);
    tick();
    check("msk_blocked", 32'(int_req), 32'h0);
    read_chk("msk_pend", 2'd2, 32'h80);
    cfg_write(2'd0, 32'hFF);
    check("msk_prewrite", 32'(int_req), 32'h0);
    tick();
    check("msk_req", 32'(int_req), 32'h1);
    check("msk_vec", int_vec,      32'h3C);
    ack();
    do_eret();

    // no nesting: edge on src 0 during SERVICE of src 6
    pulse_src(8'h40);
    tick();
    check("nest_id6", 32'(int_id), 32'h6);
    ack();
    pulse_src(8'h01);
    tick();
    check("nest_req",  32'(int_req), 32'h0);
    check("nest_busy", 32'(busy),    32'h1);
    read_chk("nest_pend",   2'd2, 32'h01);
    read_chk("nest_status", 2'd3, 32'h603);
    do_eret();
    check("nest_idle_req", 32'(int_req), 32'h0);
    tick();
    check("nest_req0", 32'(int_req), 32'h1);
    check("nest_id0",  32'(int_id),  32'h0);
    check("nest_vec0", int_vec,      32'h4);
    ack();
    do_eret();

    // W1C coincident with a new edge on src 4 (GIE off so nothing is serviced)
    cfg_write(2'd3, 32'h0);
    pulse_src(8'h10);
    tick();
    read_chk("w1c_pend_set", 2'd2, 32'h10);
    check("gie_off_req", 32'(int_req), 32'h0);
    irq_src = 8'h10;
    cfg_write(2'd2, 32'h10);
    irq_src = 8'h00;
    read_chk("w1c_edge_wins", 2'd2, 32'h10);
    cfg_write(2'd2, 32'h10);
    read_chk("w1c_cleared", 2'd2, 32'h0);
    cfg_write(2'd3, 32'h1);

    // asynchronous reset in SERVICE
    pulse_src(8'h04);
    tick();
    ack();
    check("ares_pre_busy", 32'(busy), 32'h1);
    cfg_addr = 2'd0;
    reset = 1'b0;
    #1;
    check("ares_busy",    32'(busy),      32'h0);
    check("ares_int_req", 32'(int_req),   32'h0);
    check("ares_mask",    cfg_rdata,      32'h0);
    check("ares_vec",     int_vec,        32'h4);
    check("ares_state",   32'(dbg_state), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 8, number of interrupt sources, legal range 1..32.
REQ-002 SHALL have parameter VEC_BASE, default 32'h0000_0004, vector address of source 0.
REQ-003 SHALL have parameter VEC_SHIFT, default 3, vector stride = 2**VEC_SHIFT bytes; ID_W = max(1, clog2(N_SRC)).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port irq_src  input  N_SRC  raw interrupt lines, synchronous to clk.
REQ-007 SHALL have port cfg_we  input  1  config write strobe.
REQ-008 SHALL have port cfg_addr  input  2  register select: 0 MASK, 1 MODE, 2 PENDING, 3 STATUS.
REQ-009 SHALL have port cfg_wdata  input  32  write data; bits above N_SRC ignored.
REQ-010 SHALL have port cfg_rdata  output  32  combinational read of selected register, unused bits 0.
REQ-011 SHALL have port int_req  output  1  interrupt request to CPU INT input.
REQ-012 SHALL have port int_ack  input  1  one-cycle pulse, CPU entering trap.
REQ-013 SHALL have port int_id  output  ID_W  winning source index.
REQ-014 SHALL have port int_vec  output  32  VEC_BASE + (int_id << VEC_SHIFT).
REQ-015 SHALL have port eret  input  1  one-cycle pulse, CPU executed eret.
REQ-016 SHALL have port busy  output  1  handler in service.

Function
REQ-017 MODE bit i SHALL select edge (1) or level (0) detection for source i.
REQ-018 Edge mode: rising edge of irq_src[i] (vs. registered previous value) SHALL set PENDING[i] on that clock edge; it stays set until cleared.
REQ-019 Level mode: PENDING[i] SHALL register irq_src[i] every cycle.
REQ-020 Write to PENDING SHALL be write-1-to-clear for edge-mode bits, ignored for level-mode bits; a simultaneous new edge SHALL win (bit stays 1).
REQ-021 STATUS SHALL read {in-service id at [15:8], busy at [1], GIE at [0]}; writes update only GIE.
REQ-022 eligible SHALL equal PENDING & MASK & {N_SRC{GIE}}; lowest index has highest priority.
REQ-023 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-024 IDLE: if eligible != 0, SHALL latch winning id into int_id and enter REQ next edge.
REQ-025 REQ: int_req SHALL be 1 and int_id/int_vec stable; on int_ack SHALL enter SERVICE and clear the latched id's PENDING bit if edge mode.
REQ-026 REQ: if eligible[int_id] drops with no int_ack, SHALL return to IDLE with int_req 0 next cycle; int_ack wins if coincident.
REQ-027 SERVICE: busy SHALL be 1, int_req 0, no new request (no nesting); pending bits continue to accumulate; eret SHALL return to IDLE.
REQ-028 eret outside SERVICE and int_ack outside REQ SHALL be ignored.
REQ-029 Config writes SHALL take effect on the next edge; FSM decisions in the same cycle use pre-write values.
REQ-030 Latency: irq edge sampled at edge k sets PENDING at k; int_req SHALL be 1 after edge k+1.
REQ-031 Back-to-back: eret with another eligible source SHALL give IDLE, then REQ one cycle later.

Reset
REQ-032 While reset=0: MASK, MODE, PENDING, GIE, edge history, int_id SHALL be 0; state IDLE; int_req 0, busy 0, int_vec VEC_BASE.
REQ-033 Reset assertion mid-REQ or mid-SERVICE SHALL immediately drop int_req and busy without waiting for a clock.
REQ-034 After release, first edge-detection cycle SHALL treat prior history as 0 (line high at release counts as an edge).

Verification
REQ-035 Defaults: MASK=0xFF, MODE=0xFF, GIE=1, pulse irq_src[2] -> int_req=1 after 2 edges, int_id=2, int_vec=0x14.
REQ-036 irq_src[5] and [1] rise together -> int_id=1; after ack+eret, int_id=5 request one cycle after IDLE.
REQ-037 In REQ on src 3 (level), deassert irq_src[3] before ack -> int_req 0 next cycle, state IDLE, busy 0.
REQ-038 In SERVICE, new edge on src 0 -> int_req stays 0, PENDING[0]=1; eret -> int_req=1 with int_id=0.
REQ-039 W1C PENDING[4] in same cycle as new edge on src 4 -> PENDING[4] remains 1.
REQ-040 reset=0 asynchronously during SERVICE -> busy, int_req, cfg_rdata of MASK all 0 before next clk edge.
